// File: rtl/wb_regfile_pkg.sv
// Shared sizing constants for the writeback stage and register file.
// Optional same-cycle write-through bypass is enabled with macro WB_BYPASS_EN.
package wb_regfile_pkg;

    localparam int DSIZE = 32;
    localparam int ISIZE = 16;
    localparam int ASIZE = 5;

    localparam logic [ASIZE-1:0] ZERO_REG = 5'd0;

endpackage : wb_regfile_pkg

// File: rtl/wb_regfile_regfile_core.sv
// 2^AW x DW register array: one synchronous write port, two combinational
// read ports, register 0 forced to zero, synchronous clear.
module regfile_core
    import wb_regfile_pkg::*;
#(
    parameter int DW = DSIZE,
    parameter int AW = ASIZE
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    output logic [DW-1:0] rdata1,
    output logic [DW-1:0] rdata2
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] regs_r [DEPTH];

    // Clear has priority over a concurrent write; index 0 never stores data.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= '0;
            end
        end else if (we && (waddr != AW'(ZERO_REG))) begin
            regs_r[waddr] <= wdata;
        end else begin
            regs_r[waddr] <= regs_r[waddr];
        end
    end

    // Read ports, register 0 returns zero regardless of array contents.
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (raddr1 != AW'(ZERO_REG)) begin
            rdata1 = regs_r[raddr1];
        end else begin
            rdata1 = '0;
        end
        if (raddr2 != AW'(ZERO_REG)) begin
            rdata2 = regs_r[raddr2];
        end else begin
            rdata2 = '0;
        end
    end

endmodule : regfile_core

// File: rtl/wb_regfile.sv
// Writeback select, register-file commit, operand reads and retire counter.
// Define WB_BYPASS_EN to forward the writeback value to same-cycle reads.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DSIZE_P = DSIZE,
    parameter int ISIZE_P = ISIZE,
    parameter int ASIZE_P = ASIZE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DSIZE_P-1:0] aluout_in,
    input  logic [DSIZE_P-1:0] mem_rdata_in,
    input  logic               MemtoReg_in,
    input  logic               wen_in,
    input  logic               jal_in,
    input  logic [ISIZE_P-1:0] PC_in,
    input  logic [ASIZE_P-1:0] waddr_in,
    input  logic [ASIZE_P-1:0] raddr1,
    input  logic [ASIZE_P-1:0] raddr2,
    output logic [DSIZE_P-1:0] rdata1,
    output logic [DSIZE_P-1:0] rdata2,
    output logic [DSIZE_P-1:0] wb_data,
    output logic [31:0]        retire_cnt
);

    logic               commit_s;
    logic [DSIZE_P-1:0] core_rdata1_s;
    logic [DSIZE_P-1:0] core_rdata2_s;
    logic [31:0]        retire_cnt_r;

    // Writeback source priority: link PC, then memory word, then ALU result.
    always_comb begin
        wb_data = '0;
        if (jal_in) begin
            wb_data = DSIZE_P'(PC_in);
        end else if (MemtoReg_in) begin
            wb_data = mem_rdata_in;
        end else begin
            wb_data = aluout_in;
        end
    end

    assign commit_s = wen_in && (waddr_in != ASIZE_P'(ZERO_REG));

    regfile_core #(
        .DW (DSIZE_P),
        .AW (ASIZE_P)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .we     (commit_s),
        .waddr  (waddr_in),
        .wdata  (wb_data),
        .raddr1 (raddr1),
        .raddr2 (raddr2),
        .rdata1 (core_rdata1_s),
        .rdata2 (core_rdata2_s)
    );

    // Counts every enabled write, including those aimed at register 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt_r <= 32'd0;
        end else if (wen_in) begin
            retire_cnt_r <= retire_cnt_r + 32'd1;
        end else begin
            retire_cnt_r <= retire_cnt_r;
        end
    end

    assign retire_cnt = retire_cnt_r;

`ifdef WB_BYPASS_EN
    // Write-through: decode sees the value being committed this cycle.
    always_comb begin
        rdata1 = core_rdata1_s;
        rdata2 = core_rdata2_s;
        if (!rst && commit_s && (raddr1 == waddr_in)) begin
            rdata1 = wb_data;
        end else begin
            rdata1 = core_rdata1_s;
        end
        if (!rst && commit_s && (raddr2 == waddr_in)) begin
            rdata2 = wb_data;
        end else begin
            rdata2 = core_rdata2_s;
        end
    end
`else
    assign rdata1 = core_rdata1_s;
    assign rdata2 = core_rdata2_s;
`endif

endmodule : wb_regfile

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage and architectural register file for the 5-stage pipeline. It consumes the MEM/WB pipeline register outputs (ALU result, memory-to-register select, write enable, link PC, jal flag, destination address) together with the data-memory read word. It selects the writeback value, commits it to a 2-read/1-write register file, and serves the decode stage's operand reads with optional same-cycle write-through bypass.

## Interface
Parameters:
- DSIZE, 32, data/register width (taken from the shared define header)
- ISIZE, 16, PC width; ISIZE ≤ DSIZE
- ASIZE, 5, register address width; depth = 2^ASIZE

Ports:
- clk  input  1  single clock; all state updates on posedge
- rst  input  1  synchronous, active-high reset
- aluout_in  input  DSIZE  ALU result from MEM/WB register
- mem_rdata_in  input  DSIZE  data-memory read word, cycle-aligned with aluout_in
- MemtoReg_in  input  1  1 selects mem_rdata_in as writeback data
- wen_in  input  1  register write enable
- jal_in  input  1  1 selects link PC as writeback data
- PC_in  input  ISIZE  link address, already computed upstream
- waddr_in  input  ASIZE  destination register
- raddr1, raddr2  input  ASIZE  decode-stage read addresses
- rdata1, rdata2  output  DSIZE  read data, combinational
- wb_data  output  DSIZE  selected writeback value, combinational
- retire_cnt  output  32  count of committed writes

## Operation
- Writeback select, priority order: jal_in → {zero-extended PC_in}; else MemtoReg_in → mem_rdata_in; else aluout_in.
- Commit: on posedge with wen_in=1 and waddr_in≠0, reg[waddr_in] ← wb_data.
- Register 0 hardwired to zero: writes discarded, reads always return 0 (including bypass path).
- retire_cnt increments by 1 on each posedge where wen_in=1 (regardless of waddr_in); wraps 0xFFFFFFFF → 0.
- Reads: rdataN = reg[raddrN], or bypass value (see Configuration).
- Both read ports may address the same register; both return identical data.
- jal_in and MemtoReg_in both high: jal wins, no error.

## Timing
- Reset (synchronous): on posedge with rst=1, all registers ← 0, retire_cnt ← 0; any concurrent write is dropped. rdata1/rdata2 read 0 from the cycle after the reset edge.
- wb_data: zero-latency combinational from inputs.
- Write latency: value committed at edge N is visible on rdataN (without bypass) from cycle N+1.
- Reset mid-stream: rst overrides wen_in; retire_cnt does not count the dropped write.
- Write and read same address same cycle: behaviour set by Configuration.

## Configuration
- Macro WB_BYPASS_EN.
- Defined: if wen_in=1, waddr_in≠0 and raddrN==waddr_in, rdataN = wb_data in the same cycle (write-through; decode sees the writeback result without a stall). Bypass is suppressed while rst=1.
- Undefined: rdataN always returns stored array contents; same-cycle read returns the old value, and the hazard unit must cover the extra cycle.

## Structure
- Shared define header holds DSIZE, ISIZE, ASIZE and the zero-register index constant; no new typedefs.
- One sub-module: regfile_core (2^ASIZE×DSIZE array, one synchronous write port, two combinational read ports, r0 forced zero, synchronous clear). wb_regfile contains the writeback mux, bypass logic and retire counter.

## Test plan
- Reset: write regs 1..31 with nonzero data, assert rst one cycle → all rdata read 0, retire_cnt=0.
- Select priority: aluout_in=0x11, mem_rdata_in=0x22, PC_in=0x0040, waddr_in=5, wen_in=1; cycle through {jal,MemtoReg}={0,0},{0,1},{1,0},{1,1} → reg5 = 0x11, 0x22, 0x40, 0x40.
- Zero register: wen_in=1, waddr_in=0, aluout_in=0xDEADBEEF → rdata1 (raddr1=0) stays 0 same cycle and after; retire_cnt still increments.
- Bypass: reg7=0xA, write 0xB to reg7 with raddr1=raddr2=7 in same cycle → with WB_BYPASS_EN both 0xB that cycle; without, 0xA that cycle and 0xB next.
- Counter wrap: preload by 2^32−1 writes or force via hierarchical deposit to 0xFFFFFFFF, one more write → retire_cnt=0.
- Reset collision: rst=1 with wen_in=1, waddr_in=3, aluout_in=0x55 → reg3=0 and retire_cnt=0 after the edge.
